// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: step sequencer for the Goldschmidt fpdiv datapath.
// Drives the mux selects and register enables through the setup, refinement,
// final-multiply and rounding steps, then pulses done.
//
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   start, rmode_in  : divide request (sampled in IDLE) and rounding mode
//   busy, done       : sequence in flight / one-cycle completion pulse
//   sel_muxa/b       : datapath mux selects
//   enA/enB/enC/enR  : datapath register enables
//   rMode            : rounding mode captured at the accepted start
module fpdiv_ctrl #(
  parameter int ITER   = 3,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rmode_in,
  output logic       busy,
  output logic       done,
  output logic [1:0] sel_muxa,
  output logic [1:0] sel_muxb,
  output logic       enA,
  output logic       enB,
  output logic       enC,
  output logic       enR,
  output logic       rMode
);

  localparam int NSTEP = 2 * ITER + 3;
  localparam int SW    = 5;

  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);
  localparam logic [1:0]    LAST_SET  =
    2'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam bit NO_SETTLE = (SETTLE == 0);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    ROUND,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [SW-1:0]   step_q;
  logic [SW-1:0]   step_d;
  logic [1:0]      set_q;
  logic [1:0]      set_d;
  logic            rmode_d;

  logic            busy_d;
  logic            done_d;
  logic [1:0]      sa_d;
  logic [1:0]      sb_d;
  logic            ena_d;
  logic            enb_d;
  logic            enc_d;
  logic            enr_d;

  logic            s_first;
  logic            s_second;
  logic            s_ac;
  logic            s_b;
  logic [1:0]      step_sa;
  logic [1:0]      step_sb;

  // State, counters and all outputs are registered together, so the
  // outputs are decoded from the next state rather than the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      set_q    <= '0;
      rMode    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sel_muxa <= 2'b00;
      sel_muxb <= 2'b00;
      enA      <= 1'b0;
      enB      <= 1'b0;
      enC      <= 1'b0;
      enR      <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      set_q    <= set_d;
      rMode    <= rmode_d;
      busy     <= busy_d;
      done     <= done_d;
      sel_muxa <= sa_d;
      sel_muxb <= sb_d;
      enA      <= ena_d;
      enB      <= enb_d;
      enC      <= enc_d;
      enR      <= enr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    set_d   = set_q;
    rmode_d = rMode;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rmode_d = rmode_in;
          step_d  = '0;
          set_d   = '0;
          state_d = NO_SETTLE ? FIRE : SETUP;
        end
      end
      SETUP: begin
        if (set_q == LAST_SET) begin
          set_d   = '0;
          state_d = FIRE;
        end else begin
          set_d = set_q + 2'd1;
        end
      end
      FIRE: begin
        if (step_q == LAST_STEP) begin
          state_d = ROUND;
        end else begin
          step_d  = step_q + 5'd1;
          set_d   = '0;
          state_d = NO_SETTLE ? FIRE : SETUP;
        end
      end
      ROUND: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Step table: steps 0 and 1 are the initial multiply; afterwards odd
  // steps are A/C updates and even steps (including the last) are B.
  always_comb begin
    s_first  = (step_d == 5'd0);
    s_second = (step_d == 5'd1);
    s_ac     = step_d[0] && !s_second;
    s_b      = !step_d[0] && !s_first;
    step_sa  = 2'b00;
    step_sb  = 2'b00;
    unique case (1'b1)
      s_first: begin
        step_sa = 2'b10;
        step_sb = 2'b01;
      end
      s_second: begin
        step_sa = 2'b10;
        step_sb = 2'b00;
      end
      s_ac: begin
        step_sa = 2'b00;
        step_sb = 2'b11;
      end
      s_b: begin
        step_sa = 2'b00;
        step_sb = 2'b10;
      end
      default: begin
        step_sa = 2'b00;
        step_sb = 2'b00;
      end
    endcase
  end

  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    sa_d   = 2'b00;
    sb_d   = 2'b00;
    ena_d  = 1'b0;
    enb_d  = 1'b0;
    enc_d  = 1'b0;
    enr_d  = 1'b0;
    unique case (state_d)
      SETUP: begin
        busy_d = 1'b1;
        sa_d   = step_sa;
        sb_d   = step_sb;
      end
      FIRE: begin
        busy_d = 1'b1;
        sa_d   = step_sa;
        sb_d   = step_sb;
        enb_d  = !step_d[0];
        ena_d  = step_d[0];
        enc_d  = step_d[0];
      end
      ROUND: begin
        busy_d = 1'b1;
        sb_d   = 2'b10;
        enr_d  = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: checks three fpdiv_ctrl configurations against a
// cycle-offset schedule model, plus literal expectations for key cycles.
module tb_fpdiv_ctrl;

  localparam int NC = 3;
  localparam int ITS [NC] = '{3, 1, 7};
  localparam int STS [NC] = '{1, 0, 3};
  localparam int SEL_A [9] = '{0, 2, 2, 2, 2, 0, 0, 0, 0};
  localparam int SEL_B [9] = '{0, 1, 1, 0, 0, 2, 2, 3, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic rmode_in = 1'b0;

  logic       busy_w [NC];
  logic       done_w [NC];
  logic [1:0] sa_w [NC];
  logic [1:0] sb_w [NC];
  logic       ea_w [NC];
  logic       eb_w [NC];
  logic       ec_w [NC];
  logic       er_w [NC];
  logic       rm_w [NC];
  logic [10:0] obs [NC];

  int  off [NC] = '{0, 0, 0};
  bit  rm [NC] = '{0, 0, 0};
  int  ncmp = 0;
  int  nfail = 0;
  logic [3:0] prev_sel [NC];

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITER(3), .SETTLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .rmode_in(rmode_in),
    .busy(busy_w[0]), .done(done_w[0]),
    .sel_muxa(sa_w[0]), .sel_muxb(sb_w[0]),
    .enA(ea_w[0]), .enB(eb_w[0]), .enC(ec_w[0]), .enR(er_w[0]),
    .rMode(rm_w[0])
  );

  fpdiv_ctrl #(.ITER(1), .SETTLE(0)) u1 (
    .clk(clk), .reset(reset), .start(start), .rmode_in(rmode_in),
    .busy(busy_w[1]), .done(done_w[1]),
    .sel_muxa(sa_w[1]), .sel_muxb(sb_w[1]),
    .enA(ea_w[1]), .enB(eb_w[1]), .enC(ec_w[1]), .enR(er_w[1]),
    .rMode(rm_w[1])
  );

  fpdiv_ctrl #(.ITER(7), .SETTLE(3)) u2 (
    .clk(clk), .reset(reset), .start(start), .rmode_in(rmode_in),
    .busy(busy_w[2]), .done(done_w[2]),
    .sel_muxa(sa_w[2]), .sel_muxb(sb_w[2]),
    .enA(ea_w[2]), .enB(eb_w[2]), .enC(ec_w[2]), .enR(er_w[2]),
    .rMode(rm_w[2])
  );

  for (genvar g = 0; g < NC; g++) begin : g_obs
    assign obs[g] = {busy_w[g], done_w[g], sa_w[g], sb_w[g],
                     ea_w[g], eb_w[g], ec_w[g], er_w[g], rm_w[g]};
  end

  function automatic int seq_len(int it, int st);
    return (2 * it + 3) * (st + 1) + 2;
  endfunction

  // Expected outputs t cycles after an accepted start (t=0: idle).
  function automatic logic [10:0] expect_out(int t, int it, int st,
                                             bit r);
    int nstep;
    int p;
    int k;
    logic b, d, ea, eb, ec, er;
    logic [1:0] sa, sb;
    nstep = 2 * it + 3;
    p = st + 1;
    b = 0; d = 0; ea = 0; eb = 0; ec = 0; er = 0;
    sa = 0; sb = 0;
    if (t >= 1 && t <= nstep * p) begin
      b = 1;
      k = (t - 1) / p;
      if (k == 0) begin sa = 2; sb = 1; end
      else if (k == 1) begin sa = 2; sb = 0; end
      else if (k % 2 == 0) begin sa = 0; sb = 2; end
      else begin sa = 0; sb = 3; end
      if (t % p == 0) begin
        if (k % 2 == 0) eb = 1;
        else begin ea = 1; ec = 1; end
      end
    end else if (t == nstep * p + 1) begin
      b = 1; sb = 2; er = 1;
    end else if (t == nstep * p + 2) begin
      d = 1;
    end
    return {b, d, sa, sb, ea, eb, ec, er, r};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (reset) begin
        off[i] <= 0;
        rm[i]  <= 1'b0;
      end else if (off[i] == 0) begin
        if (start) begin
          off[i] <= 1;
          rm[i]  <= rmode_in;
        end
      end else if (off[i] == seq_len(ITS[i], STS[i])) begin
        off[i] <= 0;
      end else begin
        off[i] <= off[i] + 1;
      end
    end
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_cycle();
    logic [10:0] e;
    int nen;
    for (int i = 0; i < NC; i++) begin
      e = expect_out(off[i], ITS[i], STS[i], rm[i]);
      check($sformatf("cfg%0d outputs t=%0d", i, off[i]),
            64'(obs[i]), 64'(e));
      nen = int'(eb_w[i]) + int'(ea_w[i] | ec_w[i]) + int'(er_w[i]);
      check($sformatf("cfg%0d enable exclusivity", i),
            64'(nen > 1), 64'd0);
      check($sformatf("cfg%0d enA==enC", i),
            64'(ea_w[i] ^ ec_w[i]), 64'd0);
      if (STS[i] > 0 && (ea_w[i] | eb_w[i]))
        check($sformatf("cfg%0d selects stable into fire", i),
              64'({sa_w[i], sb_w[i]}), 64'(prev_sel[i]));
      prev_sel[i] = {sa_w[i], sb_w[i]};
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
  endtask

  logic [63:0] enb0, ac0, busy0, enr0, done0;
  logic [63:0] enb1, ac1, enr1, done1;
  logic [63:0] dmask;
  bit hold;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rmode_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tick();

    // Defaults pulse with rmode 1, ignored pulses at c5/c20, accept at c21.
    enb0 = 0; ac0 = 0; busy0 = 0; enr0 = 0; done0 = 0;
    enb1 = 0; ac1 = 0; enr1 = 0; done1 = 0;
    reset = 1'b0;
    start = 1'b1;
    rmode_in = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick();
      enb0[n] = eb_w[0];
      ac0[n] = ea_w[0] & ec_w[0];
      busy0[n] = busy_w[0];
      enr0[n] = er_w[0];
      done0[n] = done_w[0];
      enb1[n] = eb_w[1];
      ac1[n] = ea_w[1] & ec_w[1];
      enr1[n] = er_w[1];
      done1[n] = done_w[1];
      if (n <= 8)
        check($sformatf("sel c%0d", n), 64'({sa_w[0], sb_w[0]}),
              64'({2'(SEL_A[n]), 2'(SEL_B[n])}));
      if (n == 1 || n == 10)
        check($sformatf("rMode c%0d", n), 64'(rm_w[0]), 64'd1);
      if (n == 22) begin
        check("step0 sel after reaccept", 64'({sa_w[0], sb_w[0]}),
              64'h9);
        check("rMode after reaccept", 64'(rm_w[0]), 64'd0);
      end
      if (n == 3) rmode_in = 1'b0;
      start = (n == 5 || n == 20 || n == 21);
    end
    start = 1'b0;
    check("cfg0 enB cycles", 64'(enb0[20:0]), 64'h044444);
    check("cfg0 enA/enC cycles", 64'(ac0[20:0]), 64'h011110);
    check("cfg0 busy cycles", 64'(busy0[20:0]), 64'h0FFFFE);
    check("cfg0 enR cycles", 64'(enr0[20:0]), 64'h080000);
    check("cfg0 single done", done0, 64'h100000);
    check("cfg1 enB cycles", 64'(enb1[15:0]), 64'h2A);
    check("cfg1 enA/enC cycles", 64'(ac1[15:0]), 64'h14);
    check("cfg1 enR cycles", 64'(enr1[15:0]), 64'h40);
    check("cfg1 done cycles", 64'(done1[15:0]), 64'h80);

    // Reset in c9 aborts the sequence with no done.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    start = 1'b1;
    rmode_in = 1'b1;
    dmask = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 10)
        check("all outputs zero after reset", 64'(obs[0]), 64'd0);
      if (n >= 10) dmask[n] = done_w[0];
      start = 1'b0;
      reset = (n == 9);
    end
    reset = 1'b0;
    check("no done after reset", dmask, 64'd0);

    // Random start/reset/rmode traffic, including long held starts.
    hold = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      tick();
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      reset = ($urandom_range(0, 299) == 0);
      start = hold | ($urandom_range(0, 3) == 0);
      rmode_in = 1'($urandom);
    end
    reset = 1'b0;
    start = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencing controller for the `fpdiv` Goldschmidt divider datapath. It accepts a start request and generates the per-cycle `sel_muxa`/`sel_muxb` selects and the `enA`/`enB`/`enC`/`enR` register enables that step the datapath through its initial multiply, its refinement iterations, the final quotient multiply and rounding. It then raises `done`. It sits beside `fpdiv` in the divide unit and replaces hand-driven control sequencing.

## Interface
Parameters:
- `ITER`, default 3: number of refinement iterations. Each iteration is one enB step plus one enA/enC step. Legal range 1..7.
- `SETTLE`, default 1: number of mux-settle cycles, with all enables low, before each enable cycle. Legal range 0..3.

Ports:
- `clk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a divide. Sampled only in IDLE.
- `rmode_in`  in  1: rounding mode. Captured when `start` is accepted.
- `busy`  out  1: high from the cycle after `start` is accepted through the ROUND cycle.
- `done`  out  1: one-cycle pulse when the sequence completes.
- `sel_muxa`  out  2: datapath mux A select.
- `sel_muxb`  out  2: datapath mux B select.
- `enA`, `enB`, `enC`, `enR`  out  1 each: datapath register enables.
- `rMode`  out  1: captured rounding mode. Held stable until the next accepted `start`.

## Operation
- All outputs are registered.
- Reset values: `busy=0`, `done=0`, `sel_muxa=00`, `sel_muxb=00`, all enables 0, `rMode=0`, state IDLE.
- States: IDLE, SETUP, FIRE, ROUND, DONE.
- Step list, `NSTEP = 2*ITER+3` entries, given as (sel_muxa, sel_muxb, enables):
  - step 0: (10, 01, enB)
  - step 1: (10, 00, enA+enC)
  - then ITER repetitions of { (00, 10, enB), (00, 11, enA+enC) }
  - final step: (00, 10, enB)
- IDLE: outputs at reset values except `rMode`, which holds. When `start=1`, latch `rmode_in` into `rMode`, clear the step counter, and go to SETUP. If `SETTLE=0`, go directly to FIRE.
- SETUP: drive the current step's selects with all enables 0 for `SETTLE` cycles, counted by the settle counter, then go to FIRE.
- FIRE: drive the same selects plus that step's enables for exactly one cycle.
  - If this is not the last step, increment the step counter and go to SETUP (or FIRE when `SETTLE=0`).
  - If it is the last step, go to ROUND.
- ROUND: `enR=1` for one cycle, with selects held at (00, 10). Then go to DONE.
- DONE: `done=1` and `busy=0` for one cycle, with selects at 00/00. Then go to IDLE.
- `start` is ignored outside IDLE, including in the DONE cycle.
- Selects never change inside a FIRE cycle. They are stable for at least `SETTLE` cycles before any enable rises.
- At most one of {enB, enA|enC, enR} is high in any cycle. `enA` and `enC` are always asserted together.

## Timing
- Let c0 be the cycle in which `start` is sampled high in IDLE.
- Step k occupies cycles c0+1+k*(SETTLE+1) through c0+(k+1)*(SETTLE+1). The FIRE cycle is the last of these.
- ROUND is at c0+NSTEP*(SETTLE+1)+1. DONE is one cycle later.
- Latency from `start` to `done` is NSTEP*(SETTLE+1)+2 cycles. With the defaults this is 20 cycles: `enR` in c19, `done` in c20.
- The earliest next accept is the cycle after DONE, i.e. c0+21 with the defaults.
- Reset mid-sequence: in the next cycle all outputs take their reset values. No `done` is produced and `rMode` clears to 0.
- `start` held high continuously: a new sequence begins on each IDLE cycle. Back-to-back period is latency+1 cycles.

## Test plan
- Defaults, `start` pulse at c0 with `rmode_in=1`:
  - `rMode=1` from c1.
  - `enB` high only in c2, c6, c10, c14, c18.
  - `enA=enC=1` only in c4, c8, c12, c16.
  - selects are (10,01) in c1–c2, (10,00) in c3–c4, (00,10) in c5–c6, (00,11) in c7–c8.
  - `enR` in c19, `done` in c20, `busy` high c1–c19.
- `SETTLE=0`, `ITER=1`: NSTEP=5. Enables in consecutive cycles c1..c5 in the order B, AC, B, AC, B. `enR` in c6, `done` in c7.
- `start` pulsed again at c5 and at c20 (defaults): both ignored, and only one `done`, at c20. `start` at c21 begins a new sequence with step 0 selects in c22.
- Assert `reset` at c9 (defaults): at c10 all outputs are 0. No `done` in any later cycle until the next `start`.
- Change `rmode_in` while busy: `rMode` is unchanged until the next accepted `start`.
- Every cycle over 50 random start/reset sequences, checked by assertion:
  - enables are mutually exclusive.
  - `enA==enC`.
  - selects are unchanged between a step's first SETUP cycle and its FIRE cycle.
